axi4_aw_arbiter: RTL and testbench
==================================

// Module: axi4_aw_arbiter
// PURPOSE
//  Round-robin arbiter sharing one AXI4 AW channel (feeding the RAB AW buffer) between NUM_MASTERS slave ports.
//  Holds each grant until the downstream AW handshake completes.
//  Records every granted master index in an in-order route FIFO, so the W-channel mux steers write data beats to match the AW order.
// PARAMETERS
//  NUM_MASTERS     4  number of requesting slave ports (2..8)
//  AXI_ID_WIDTH    4  AW ID width
//  AXI_USER_WIDTH  4  AW user width
//  ROUTE_DEPTH     4  route FIFO entries (power of 2, >=2); bounds outstanding AW-without-W-completion
// PORTS
//  axi4_aclk        in   1                clock
//  axi4_arstn       in   1                reset, synchronous, active-low
//  s_axi4_awvalid   in   NUM_MASTERS      per-master AW valid
//  s_axi4_awready   out  NUM_MASTERS      per-master AW ready
//  s_axi4_aw_data   in   NUM_MASTERS*AW_W packed AW beats, master i at [i*AW_W +: AW_W]
//  m_axi4_awvalid   out  1                shared AW valid
//  m_axi4_awready   in   1                shared AW ready
//  m_axi4_aw_data   out  AW_W             granted AW beat
//  w_route_sel      out  $clog2(NUM_MASTERS)  master owning the current W burst (FIFO head)
//  w_route_valid    out  1                route FIFO not empty
//  w_route_pop      in   1                W mux pulses high on the wlast handshake
// BEHAVIOUR
//  Reset (axi4_arstn=0 at a clock edge): state=IDLE, rr_ptr=0, FIFO empty; all outputs 0.
//  Outputs held at reset value: s_axi4_awready, m_axi4_awvalid, m_axi4_aw_data, w_route_sel, w_route_valid.
//  AW_W = 61+AXI_ID_WIDTH+AXI_USER_WIDTH; packing order is set by the package (cache LSB ... user MSB).
//  FSM IDLE: if any valid and FIFO not full -> pick winner, register grant, go HOLD. Latency: valid -> m_awvalid is 1 cycle.
//  Winner pick: first set valid searching from rr_ptr upward, wrapping mod NUM_MASTERS.
//  FSM HOLD outputs:
//    m_axi4_awvalid=1; m_axi4_aw_data = data of the granted master (combinational mux, registered select).
//    s_axi4_awready[grant] = m_axi4_awready; all other readies 0.
//  HOLD on handshake: push grant into the FIFO; rr_ptr = grant+1 (wrap to 0).
//    Then re-arbitrate the same cycle, with the granted master's valid masked.
//    If a winner exists and the FIFO is not full after this push: stay HOLD with the new grant (back-to-back, no bubble).
//    Otherwise go IDLE.
//  Grant never changes while m_awvalid=1 without a handshake (AXI stability); a master's valid dropping before handshake is a protocol violation (assert).
//  FIFO: full = (count==ROUTE_DEPTH) evaluated before a same-cycle pop; a full FIFO blocks new grants.
//    Push and pop in the same cycle keep count unchanged.
//    Pop when empty is ignored and flagged by assertion.
//  w_route_sel/valid reflect the FIFO head registered state; a pushed entry is visible the cycle after the push.
//  Reset mid-burst: grant dropped, FIFO flushed, no handshake completes in the reset cycle.
// CONFIGURATION
//  AXI4_AW_ARB_QOS_EN defined:
//    Winner = requester with the highest awqos (from its packed beat).
//    Ties are resolved round-robin from rr_ptr; rr_ptr is updated as above.
//  AXI4_AW_ARB_QOS_EN undefined: pure round-robin and awqos is ignored for arbitration; the beat is passed unchanged in both modes.
// STRUCTURE
//  Package axi4_aw_arb_pkg holds:
//    AW field offset/width localparams (CACHE_LSB .. USER_LSB, AW_FIXED_W=61).
//    State enum {IDLE, HOLD}.
//    Function rr_pick(req, ptr) returning the winner index plus a found flag.
//  Sub-module axi4_aw_arb_route_fifo: ROUTE_DEPTH x $clog2(NUM_MASTERS) synchronous FIFO with count, full, empty.
// TESTING
//  1. Single master 2 sends 3 AWs, awready=1 -> m_awvalid 1 cycle after valid; back-to-back from master 2 only after one masked cycle; FIFO holds 2,2,2.
//  2. All 4 valid continuously, awready=1 -> grant order 0,1,2,3,0,... with no idle cycles between grants.
//  3. Master 1 granted, awready=0 for 5 cycles -> m_aw_data stable = master 1 beat; s_awready all 0; master 3 valid meanwhile is not granted.
//  4. ROUTE_DEPTH=4, no pops, 6 requests -> exactly 4 handshakes then m_awvalid=0; one w_route_pop -> the 5th AW is granted the next cycle.
//  5. Assert axi4_arstn=0 while in HOLD with FIFO count 3 -> next cycle all outputs 0, w_route_valid=0, next grant starts from master 0.
//  6. QOS_EN, masters 0/1/2 with qos 1/7/7, rr_ptr=2 -> grant 2, then 1, then 0.

Source files
------------

// File: rtl/axi4_aw_arb_pkg.sv
// Shared AW-arbiter types: AW beat field layout, FSM states and the
// round-robin picker used by axi4_aw_arbiter.
package axi4_aw_arb_pkg;

  localparam int unsigned CACHE_LSB  = 0;
  localparam int unsigned CACHE_W    = 4;
  localparam int unsigned PROT_LSB   = 4;
  localparam int unsigned PROT_W     = 3;
  localparam int unsigned QOS_LSB    = 7;
  localparam int unsigned QOS_W      = 4;
  localparam int unsigned REGION_LSB = 11;
  localparam int unsigned REGION_W   = 4;
  localparam int unsigned LOCK_LSB   = 15;
  localparam int unsigned BURST_LSB  = 16;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned SIZE_LSB   = 18;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned LEN_LSB    = 21;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned ADDR_LSB   = 29;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned AW_FIXED_W = 61;
  localparam int unsigned ID_LSB     = AW_FIXED_W;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Unused upper request bits must be zero, so a mod-8 scan equals mod-N.
  function automatic rr_pick_t rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr
  );
    rr_pick_t   r;
    logic [2:0] k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = ptr + 3'(i);
      if (!r.found && req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_aw_arb_route_fifo.sv
// In-order route FIFO recording which master owns each granted AW,
// popped by the W mux on every wlast handshake.
module axi4_aw_arb_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign head   = empty ? '0 : mem_q[rd_q];
  assign pop_ok = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  a_pop_empty: assert property (
    @(posedge clk) disable iff (!rst_n) pop |-> !empty
  );

endmodule

// File: rtl/axi4_aw_arbiter.sv
// Round-robin AW-channel arbiter with in-order W route FIFO.
// Define AXI4_AW_ARB_QOS_EN for highest-awqos-first arbitration.
module axi4_aw_arbiter
  import axi4_aw_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int ROUTE_DEPTH    = 4
) (
  input  logic axi4_aclk,
  input  logic axi4_arstn,
  input  logic [NUM_MASTERS-1:0] s_axi4_awvalid,
  output logic [NUM_MASTERS-1:0] s_axi4_awready,
  input  logic [NUM_MASTERS*(AW_FIXED_W+AXI_ID_WIDTH+AXI_USER_WIDTH)-1:0]
               s_axi4_aw_data,
  output logic m_axi4_awvalid,
  input  logic m_axi4_awready,
  output logic [AW_FIXED_W+AXI_ID_WIDTH+AXI_USER_WIDTH-1:0]
               m_axi4_aw_data,
  output logic [$clog2(NUM_MASTERS)-1:0] w_route_sel,
  output logic w_route_valid,
  input  logic w_route_pop
);

  localparam int AW_W  = AW_FIXED_W + AXI_ID_WIDTH + AXI_USER_WIDTH;
  localparam int SEL_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(ROUTE_DEPTH) + 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_MASTERS - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] ptr_nx;
  logic [NUM_MASTERS-1:0] grant_oh;
  rr_pick_t         idle_pick, hold_pick;
  logic             push;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             room_after_push;

`ifdef AXI4_AW_ARB_QOS_EN
  logic [NUM_MASTERS-1:0][QOS_W-1:0] qos;

  always_comb begin
    qos = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      qos[i] = s_axi4_aw_data[i*AW_W+QOS_LSB +: QOS_W];
  end

  // Only requesters at the top qos level enter the round-robin scan.
  function automatic rr_pick_t arb(
    input logic [NUM_MASTERS-1:0]            req,
    input logic [SEL_W-1:0]                  ptr,
    input logic [NUM_MASTERS-1:0][QOS_W-1:0] q
  );
    logic [QOS_W-1:0]       best;
    logic [NUM_MASTERS-1:0] top;
    best = '0;
    top  = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (req[i] && q[i] > best) best = q[i];
    for (int i = 0; i < NUM_MASTERS; i++)
      top[i] = req[i] && (q[i] == best);
    return rr_pick(8'(top), 3'(ptr));
  endfunction

  always_comb begin
    idle_pick = arb(s_axi4_awvalid, rr_ptr_q, qos);
    hold_pick = arb(s_axi4_awvalid & ~grant_oh, ptr_nx, qos);
  end
`else
  always_comb begin
    idle_pick = rr_pick(8'(s_axi4_awvalid), 3'(rr_ptr_q));
    hold_pick = rr_pick(8'(s_axi4_awvalid & ~grant_oh), 3'(ptr_nx));
  end
`endif

  assign grant_oh        = NUM_MASTERS'(1) << grant_q;
  assign ptr_nx          = (grant_q == LAST) ? '0 : grant_q + 1'b1;
  assign room_after_push = fifo_count < CNT_W'(ROUTE_DEPTH - 1);

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (idle_pick.found && !fifo_full) begin
          state_d = HOLD;
          grant_d = SEL_W'(idle_pick.idx);
        end
      end
      HOLD: begin
        if (m_axi4_awready) begin
          push     = 1'b1;
          rr_ptr_d = ptr_nx;
          if (hold_pick.found && room_after_push)
            grant_d = SEL_W'(hold_pick.idx);
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so no handshake is visible in the reset cycle.
  always_comb begin
    m_axi4_awvalid = 1'b0;
    s_axi4_awready = '0;
    m_axi4_aw_data = '0;
    if (state_q == HOLD && axi4_arstn) begin
      m_axi4_awvalid = 1'b1;
      s_axi4_awready = grant_oh & {NUM_MASTERS{m_axi4_awready}};
      m_axi4_aw_data = s_axi4_aw_data[grant_q*AW_W +: AW_W];
    end
  end

  axi4_aw_arb_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (SEL_W)
  ) u_route_fifo (
    .clk       (axi4_aclk),
    .rst_n     (axi4_arstn),
    .push      (push),
    .push_data (grant_q),
    .pop       (w_route_pop),
    .head      (w_route_sel),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign w_route_valid = !fifo_empty;

  a_valid_held: assert property (
    @(posedge axi4_aclk) disable iff (!axi4_arstn)
    (state_q == HOLD) |-> s_axi4_awvalid[grant_q]
  );

endmodule

// File: tb/tb_axi4_aw_arbiter.sv
// Directed bench for axi4_aw_arbiter: vector table of request mixes
// plus hand sequences for stall, FIFO-full and mid-burst reset.
module tb_axi4_aw_arbiter;
  import axi4_aw_arb_pkg::*;

  localparam int N     = 4;
  localparam int IDW   = 4;
  localparam int UW    = 4;
  localparam int DEPTH = 4;
  localparam int AW_W  = AW_FIXED_W + IDW + UW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      s_awvalid, s_awready;
  logic [N*AW_W-1:0] s_aw_data;
  logic              m_awvalid, m_awready;
  logic [AW_W-1:0]   m_aw_data;
  logic [1:0]        w_route_sel;
  logic              w_route_valid, w_route_pop;
  logic              pop_en = 1'b0;
  logic              pop_pulse = 1'b0;

  int              pending [N];
  logic [AW_W-1:0] beat [N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int log_q [$];
  int cyc_q [$];
  int rq [$];
  logic [N-1:0] hs_v;
  int idx;

  axi4_aw_arbiter #(
    .NUM_MASTERS    (N),
    .AXI_ID_WIDTH   (IDW),
    .AXI_USER_WIDTH (UW),
    .ROUTE_DEPTH    (DEPTH)
  ) dut (
    .axi4_aclk      (clk),
    .axi4_arstn     (rstn),
    .s_axi4_awvalid (s_awvalid),
    .s_axi4_awready (s_awready),
    .s_axi4_aw_data (s_aw_data),
    .m_axi4_awvalid (m_awvalid),
    .m_axi4_awready (m_awready),
    .m_axi4_aw_data (m_aw_data),
    .w_route_sel    (w_route_sel),
    .w_route_valid  (w_route_valid),
    .w_route_pop    (w_route_pop)
  );

  always_comb begin
    s_awvalid = '0;
    s_aw_data = '0;
    for (int i = 0; i < N; i++) begin
      s_awvalid[i] = pending[i] > 0;
      s_aw_data[i*AW_W +: AW_W] = beat[i];
    end
  end

  assign w_route_pop = (pop_en | pop_pulse) & w_route_valid;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW_W-1:0] mk_beat(input int i, input int q);
    logic [AW_W-1:0] b;
    b = '0;
    b[CACHE_LSB +: CACHE_W] = 4'(i + 3);
    b[QOS_LSB +: QOS_W]     = 4'(q);
    b[BURST_LSB +: BURST_W] = 2'b01;
    b[SIZE_LSB +: SIZE_W]   = 3'd2;
    b[LEN_LSB +: LEN_W]     = 8'(i + 1);
    b[ADDR_LSB +: ADDR_W]   = 32'h8000_0000 + 32'(i) * 32'h100;
    b[ID_LSB +: IDW]        = 4'(i);
    b[ID_LSB+IDW +: UW]     = 4'(15 - i);
    return b;
  endfunction

  // Monitor: AW handshakes, route FIFO pops, and the masters' AW queues.
  always @(posedge clk) begin
    cyc++;
    hs_v = s_awvalid & s_awready;
    if (!rstn) begin
      rq.delete();
    end else begin
      if (m_awvalid && m_awready) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (s_awready[i]) idx = i;
        check("awready_onehot", $countones(s_awready), 1);
        if (idx >= 0) begin
          check("aw_data", m_aw_data, beat[idx]);
          log_q.push_back(idx);
          cyc_q.push_back(cyc);
          rq.push_back(idx);
        end
      end
      if (w_route_pop) begin
        if (rq.size() == 0) check("route_pop_nonempty", 0, 1);
        else check("route_sel", w_route_sel, rq.pop_front());
      end
    end
    #1;
    for (int i = 0; i < N; i++)
      if (hs_v[i] && pending[i] > 0) pending[i]--;
  end

  typedef struct {
    int pend  [N];
    int qos   [N];
    int n;
    int ord   [8];
    int ord_q [8];
    int span;
  } vec_t;

  vec_t tbl [5];
  int   start;
  int   exp_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{'{2,2,2,2}, '{0,0,0,0}, 8,
               '{0,1,2,3,0,1,2,3}, '{0,1,2,3,0,1,2,3}, 7};
    tbl[1] = '{'{0,0,3,0}, '{0,0,0,0}, 3,
               '{2,2,2,0,0,0,0,0}, '{2,2,2,0,0,0,0,0}, 4};
    tbl[2] = '{'{1,0,1,1}, '{0,0,0,0}, 3,
               '{3,0,2,0,0,0,0,0}, '{3,0,2,0,0,0,0,0}, 2};
    tbl[3] = '{'{0,1,0,0}, '{0,0,0,0}, 1,
               '{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}, 0};
    tbl[4] = '{'{1,1,1,0}, '{1,7,7,0}, 3,
               '{2,0,1,0,0,0,0,0}, '{2,1,0,0,0,0,0,0}, 2};

    for (int i = 0; i < N; i++) begin
      pending[i] = 0;
      beat[i] = mk_beat(i, 0);
    end
    m_awready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_s_awready", s_awready, 0);
    check("rst_m_aw_data", m_aw_data, 0);
    check("rst_route_valid", w_route_valid, 0);
    check("rst_route_sel", w_route_sel, 0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) beat[i] = mk_beat(i, tbl[r].qos[i]);
      start = log_q.size();
      pending = tbl[r].pend;
      m_awready = 1'b1;
      pop_en = 1'b1;
      for (int k = 0; k < 200 && log_q.size() < start + tbl[r].n; k++)
        @(negedge clk);
      repeat (8) @(negedge clk);
      check($sformatf("row%0d_count", r), log_q.size() - start, tbl[r].n);
      for (int j = 0; j < tbl[r].n; j++) begin
`ifdef AXI4_AW_ARB_QOS_EN
        exp_i = tbl[r].ord_q[j];
`else
        exp_i = tbl[r].ord[j];
`endif
        if (start + j < log_q.size())
          check($sformatf("row%0d_grant%0d", r, j), log_q[start+j], exp_i);
      end
      if (log_q.size() >= start + tbl[r].n)
        check($sformatf("row%0d_span", r),
              cyc_q[start+tbl[r].n-1] - cyc_q[start], tbl[r].span);
      check($sformatf("row%0d_drained", r), w_route_valid, 0);
    end

    // Stall: master 1 held while master 3 waits.
    for (int i = 0; i < N; i++) beat[i] = mk_beat(i, 0);
    m_awready = 1'b0;
    start = log_q.size();
    pending[1] = 1;
    @(negedge clk);
    check("stall_latency", m_awvalid, 1);
    pending[3] = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_awvalid", m_awvalid, 1);
      check("stall_data", m_aw_data, mk_beat(1, 0));
      check("stall_readies", s_awready, 0);
    end
    m_awready = 1'b1;
    for (int k = 0; k < 50 && log_q.size() < start + 2; k++)
      @(negedge clk);
    check("stall_count", log_q.size() - start, 2);
    if (log_q.size() >= start + 2) begin
      check("stall_first", log_q[start], 1);
      check("stall_second", log_q[start+1], 3);
    end
    repeat (6) @(negedge clk);

    // Route FIFO full blocks the 5th grant until one pop.
    pop_en = 1'b0;
    start = log_q.size();
    pending[0] = 3;
    pending[1] = 3;
    repeat (15) @(negedge clk);
    check("full_count", log_q.size() - start, 4);
    check("full_awvalid", m_awvalid, 0);
    check("full_route_valid", w_route_valid, 1);
    check("full_route_sel", w_route_sel, 0);
    if (log_q.size() >= start + 4) begin
      check("full_g0", log_q[start], 0);
      check("full_g1", log_q[start+1], 1);
      check("full_g2", log_q[start+2], 0);
      check("full_g3", log_q[start+3], 1);
    end
    pop_pulse = 1'b1;
    @(negedge clk);
    pop_pulse = 1'b0;
    check("pop_idle", m_awvalid, 0);
    @(negedge clk);
    check("pop_regrant", m_awvalid, 1);
    check("pop_regrant_data", m_aw_data, mk_beat(0, 0));
    pop_en = 1'b1;
    for (int k = 0; k < 100 && (pending[0] + pending[1]) > 0; k++)
      @(negedge clk);
    repeat (8) @(negedge clk);
    check("full_drained", w_route_valid, 0);

    // Reset while holding a grant with three routes queued.
    pop_en = 1'b0;
    start = log_q.size();
    pending[2] = 5;
    for (int k = 0; k < 50 && log_q.size() < start + 3; k++)
      @(negedge clk);
    m_awready = 1'b0;
    @(negedge clk);
    check("pre_rst_awvalid", m_awvalid, 1);
    check("pre_rst_route_valid", w_route_valid, 1);
    rstn = 1'b0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    @(negedge clk);
    check("mid_rst_awvalid", m_awvalid, 0);
    check("mid_rst_readies", s_awready, 0);
    check("mid_rst_data", m_aw_data, 0);
    check("mid_rst_route_valid", w_route_valid, 0);
    check("mid_rst_route_sel", w_route_sel, 0);
    rstn = 1'b1;
    start = log_q.size();
    for (int i = 0; i < N; i++) pending[i] = 1;
    m_awready = 1'b1;
    pop_en = 1'b1;
    for (int k = 0; k < 50 && log_q.size() < start + 4; k++)
      @(negedge clk);
    check("post_rst_count", log_q.size() - start, 4);
    for (int j = 0; j < 4; j++)
      if (start + j < log_q.size())
        check($sformatf("post_rst_g%0d", j), log_q[start+j], j);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
